// File: rtl/rx_iq_pkg.sv
// Shared types and constants for the receiver I/Q byte packer.
package rx_iq_pkg;

  localparam int BYTES_PER_SAMPLE = 6;
  localparam int SAMPLE_W         = 24;
  localparam int PAIR_W           = 2 * SAMPLE_W;

  typedef logic [2:0] byte_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES_PER_SAMPLE - 1);

endpackage

// File: rtl/rx_iq_fifo.sv
// Show-ahead synchronous FIFO of I/Q pairs with registered occupancy and a
// synchronous flush. The caller never writes when full without a read, nor reads when empty.
module rx_iq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     write,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     read,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= wr_ptr + PTR_ONE;
      if (read)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({write, read})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (write && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign level = count;

endmodule

// File: rtl/rx_iq_byte_packer.sv
// Buffers 24-bit I/Q pairs and serializes each into six MSB-first bytes on a
// valid/ready stream, flagging block start/end and counting dropped samples.
module rx_iq_byte_packer
  import rx_iq_pkg::*;
#(
  parameter int DEPTH             = 16,
  parameter int SAMPLES_PER_BLOCK = 63
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    in_strobe,
  input  logic [SAMPLE_W-1:0]     in_i,
  input  logic [SAMPLE_W-1:0]     in_q,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    byte_sob,
  output logic                    byte_eob,
  output logic [$clog2(DEPTH):0]  fill_level,
  output logic                    overflow,
  output logic [15:0]             overflow_count
);

  localparam logic [7:0] LAST_SAMPLE = 8'(SAMPLES_PER_BLOCK - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state;
  state_t            state_nxt;
  byte_idx_t         byte_idx;
  byte_idx_t         byte_idx_nxt;
  logic [7:0]        sample_idx;
  logic [7:0]        sample_idx_nxt;
  logic [PAIR_W-1:0] shreg;
  logic [PAIR_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              shift;
  logic              push;
  logic              drop;
  logic              handshake;

  rx_iq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAIR_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (!enable),
    .write   (push),
    .wdata   ({in_i, in_q}),
    .read    (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  // A full FIFO still accepts when the serializer frees a slot on the same edge.
  assign push = in_strobe && enable && (!fifo_full || pop);
  assign drop = in_strobe && enable && fifo_full && !pop;

  assign handshake = byte_valid && byte_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_idx   <= '0;
      sample_idx <= '0;
    end else begin
      state      <= state_nxt;
      byte_idx   <= byte_idx_nxt;
      sample_idx <= sample_idx_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    byte_idx_nxt   = byte_idx;
    sample_idx_nxt = sample_idx;
    pop            = 1'b0;
    shift          = 1'b0;
    if (!enable) begin
      state_nxt      = IDLE;
      byte_idx_nxt   = '0;
      sample_idx_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop          = 1'b1;
            byte_idx_nxt = '0;
            state_nxt    = SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            if (byte_idx == LAST_BYTE) begin
              sample_idx_nxt = (sample_idx == LAST_SAMPLE) ? 8'd0 : sample_idx + 8'd1;
              byte_idx_nxt   = '0;
              // Reload on the last-byte edge keeps the stream free of bubbles.
              if (!fifo_empty) pop = 1'b1;
              else             state_nxt = IDLE;
            end else begin
              shift        = 1'b1;
              byte_idx_nxt = byte_idx + 3'd1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (pop)        shreg <= fifo_rdata;
    else if (shift) shreg <= {shreg[PAIR_W-9:0], 8'h00};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else if (drop) begin
      overflow       <= 1'b1;
      overflow_count <= sat_inc16(overflow_count);
    end
  end

  // The shift register is not reset, so data is masked outside SEND.
  assign byte_valid = (state == SEND);
  assign byte_data  = byte_valid ? shreg[PAIR_W-1:PAIR_W-8] : 8'h00;
  assign byte_sob   = byte_valid && (byte_idx == '0) && (sample_idx == 8'd0);
  assign byte_eob   = byte_valid && (byte_idx == LAST_BYTE) && (sample_idx == LAST_SAMPLE);

endmodule

// File: tb/tb_rx_iq_byte_packer.sv
// Scoreboard bench for rx_iq_byte_packer: stimulus pushes expected bytes,
// a negedge monitor pops and compares each accepted byte.
module tb_rx_iq_byte_packer;

  localparam int DEPTH = 16;
  localparam int SPB   = 63;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        in_strobe = 1'b0;
  logic [23:0] in_i = '0;
  logic [23:0] in_q = '0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_sob;
  logic        byte_eob;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [15:0] overflow_count;

  rx_iq_byte_packer #(
    .DEPTH             (DEPTH),
    .SAMPLES_PER_BLOCK (SPB)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .in_strobe      (in_strobe),
    .in_i           (in_i),
    .in_q           (in_q),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .byte_sob       (byte_sob),
    .byte_eob       (byte_eob),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .overflow_count (overflow_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       sob;
    logic       eob;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   blk_idx = 0;
  int   hs_total = 0;
  bit   win = 1'b0;
  int   win_hs = 0;
  int   bubbles = 0;
  logic prev_stall = 1'b0;
  logic prev_en = 1'b0;
  logic [10:0] prev_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each sample is 6 bytes of {I,Q} MSB first; block position is
  // the count of accepted samples since the last flush, modulo SPB.
  task automatic push_sample(input logic [23:0] i, input logic [23:0] q);
    logic [47:0] pair;
    exp_t e;
    pair = {i, q};
    for (int b = 0; b < 6; b++) begin
      e.d   = pair[47 - 8*b -: 8];
      e.sob = (b == 0) && (blk_idx == 0);
      e.eob = (b == 5) && (blk_idx == SPB - 1);
      exp_q.push_back(e);
    end
    blk_idx = (blk_idx + 1) % SPB;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [23:0] i, input logic [23:0] q, input bit accept);
    in_i      = i;
    in_q      = q;
    in_strobe = 1'b1;
    if (accept) push_sample(i, q);
    cycle();
    in_strobe = 1'b0;
  endtask

  task automatic flush();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    exp_q.delete();
    blk_idx = 0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    byte_ready = 1'b1;
    while (exp_q.size() != 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    cycle();
    cycle();
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (prev_stall && prev_en)
        check("stall_hold", 32'({byte_valid, byte_sob, byte_eob, byte_data}),
              32'({1'b1, prev_out[9:0]}));
      if (win && !byte_valid && win_hs > 0 && win_hs < 756) bubbles++;
      if (byte_valid && byte_ready) begin
        hs_total++;
        if (win) win_hs++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", byte_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("byte", 32'({byte_sob, byte_eob, byte_data}), 32'({mon_e.sob, mon_e.eob, mon_e.d}));
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_en    = enable;
      prev_out   = {byte_valid, byte_sob, byte_eob, byte_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hs0;

    repeat (3) cycle();
    check("rst_valid", 32'({byte_valid, byte_sob, byte_eob}), 32'd0);
    check("rst_data", 32'(byte_data), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_ovf", 32'({overflow, overflow_count}), 32'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    byte_ready = 1'b1;
    cycle();

    // single sample, two-cycle latency
    strobe(24'h123456, 24'hABCDEF, 1'b1);
    check("lat_cycle1_valid", 32'(byte_valid), 32'd0);
    cycle();
    check("lat_cycle2_valid", 32'(byte_valid), 32'd1);
    check("first_byte", 32'(byte_data), 32'h12);
    check("first_sob", 32'(byte_sob), 32'd1);
    repeat (6) cycle();
    check("idle_after_single", 32'(byte_valid), 32'd0);
    check("single_left", 32'(exp_q.size()), 32'd0);

    // back-to-back, two full blocks
    flush();
    win = 1'b1;
    win_hs = 0;
    bubbles = 0;
    for (int k = 0; k < 126; k++) begin
      strobe(24'($urandom), 24'($urandom), 1'b1);
      repeat (5) cycle();
    end
    drain(100);
    win = 1'b0;
    check("b2b_bubbles", 32'(bubbles), 32'd0);
    check("b2b_bytes", 32'(win_hs), 32'd756);

    // random backpressure
    flush();
    n = 0;
    for (int c = 0; c < 900; c++) begin
      if (c % 20 == 0 && n < 40) begin
        in_i = 24'($urandom);
        in_q = 24'($urandom);
        in_strobe = 1'b1;
        push_sample(in_i, in_q);
        n++;
      end else begin
        in_strobe = 1'b0;
      end
      byte_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    in_strobe = 1'b0;
    drain(600);
    check("bp_no_overflow", 32'({overflow, overflow_count}), 32'd0);

    // overflow under full stall
    flush();
    byte_ready = 1'b0;
    for (int k = 0; k < 20; k++) strobe(24'($urandom), 24'($urandom), k < 17);
    cycle();
    check("ovf_fill", 32'(fill_level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(overflow_count), 32'd3);
    hs0 = hs_total;
    drain(300);
    check("ovf_release_bytes", 32'(hs_total - hs0), 32'd102);

    // full FIFO with write on the same edge as the last-byte pop
    byte_ready = 1'b0;
    for (int k = 0; k < 17; k++) strobe(24'($urandom), 24'($urandom), 1'b1);
    cycle();
    check("fullpop_fill_before", 32'(fill_level), 32'd16);
    byte_ready = 1'b1;
    repeat (5) cycle();
    strobe(24'h7FFFFF, 24'h800000, 1'b1);
    check("fullpop_fill_after", 32'(fill_level), 32'd16);
    check("fullpop_count", 32'(overflow_count), 32'd3);
    drain(300);

    // flush mid-sample at byte index 3
    flush();
    byte_ready = 1'b0;
    for (int k = 0; k < 6; k++) strobe(24'($urandom), 24'($urandom), 1'b1);
    cycle();
    byte_ready = 1'b1;
    repeat (3) cycle();
    flush();
    check("flush_valid", 32'(byte_valid), 32'd0);
    check("flush_fill", 32'(fill_level), 32'd0);
    repeat (3) cycle();
    check("flush_idle", 32'(byte_valid), 32'd0);
    strobe(24'hFEDCBA, 24'h012345, 1'b1);
    cycle();
    check("flush_next_sob", 32'({byte_valid, byte_sob, byte_data}), 32'({1'b1, 1'b1, 8'hFE}));
    drain(50);
    check("flush_ovf_kept", 32'({overflow, overflow_count}), 32'({1'b1, 16'd3}));

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_iq_byte_packer.md
# rx_iq_byte_packer

Sits directly downstream of the receiver's polyphase FIR output and takes one 24-bit I/Q pair per output strobe. It buffers the pairs in a small FIFO and serializes each pair into six bytes (I then Q, MSB first) on a valid/ready byte stream. The openHPSDR frame builder consumes that stream. The block marks start/end of each block of `SAMPLES_PER_BLOCK` samples and counts FIFO overflows.

## Interface
- `DEPTH`, 16, FIFO depth in I/Q pairs; power of two, 4..64.
- `SAMPLES_PER_BLOCK`, 63, samples per frame block; 1..255.
- `clock`  in  1  receiver clock (61.44 MHz); single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high = run; low = synchronous flush.
- `in_strobe`  in  1  one-cycle pulse; `in_i`/`in_q` valid.
- `in_i`  in  24  signed I sample.
- `in_q`  in  24  signed Q sample.
- `byte_data`  out  8  current byte.
- `byte_valid`  out  1  `byte_data` valid.
- `byte_ready`  in  1  consumer accepts when `byte_valid & byte_ready`.
- `byte_sob`  out  1  current byte is byte 0 of sample 0 of a block.
- `byte_eob`  out  1  current byte is byte 5 of the last sample of a block.
- `fill_level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; set on any dropped sample.
- `overflow_count`  out  16  dropped samples, saturates at 0xFFFF.

## Operation
**Reset values**
- All outputs 0.
- FIFO empty; FSM in IDLE; sample index 0; byte index 0.

**FIFO write**
- A write occurs on `in_strobe & enable`.
- The sample is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Otherwise the sample is dropped: `overflow` is set and `overflow_count` increments, saturating.
- `in_strobe` while `enable`=0 is ignored and not counted.

**FSM**
- IDLE
  - FIFO non-empty: pop into a 48-bit shift register `{I,Q}`, byte index = 0, go to SEND.
- SEND
  - `byte_valid`=1 and `byte_data` = shift register bits [47:40].
  - On a handshake at byte index < 5: shift left by 8 and increment the byte index.
  - On a handshake at byte index 5: advance the sample index, wrapping to 0 after `SAMPLES_PER_BLOCK`-1.
    - If the FIFO is non-empty, pop and reload in the same edge and stay in SEND, with no bubble.
    - Otherwise go to IDLE.
- `byte_data`, `byte_valid`, `byte_sob` and `byte_eob` are held stable while `byte_valid & !byte_ready`.
- Byte order: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].

**Flags**
- `byte_sob` = SEND & byte index 0 & sample index 0.
- `byte_eob` = SEND & byte index 5 & sample index `SAMPLES_PER_BLOCK`-1.
- With `SAMPLES_PER_BLOCK`=1, both flags occur on every sample.

**Flush**
- `enable`=0 at a clock edge:
  - FIFO emptied, FSM to IDLE, sample index and byte index cleared.
  - `byte_valid` drops on the next cycle, even mid-handshake. This is the only permitted valid withdrawal; the consumer must discard its partial frame.
- `overflow` and `overflow_count` are not cleared by flush; only `reset_n` clears them.

**Mid-operation reset**
- `reset_n` low clears all state immediately.
- Any partially sent sample is lost.

## Timing
- Strobe to first byte:
  - `in_strobe` in cycle 0 writes at the edge ending cycle 0.
  - The FIFO is non-empty in cycle 1; pop at the edge ending cycle 1.
  - `byte_valid`=1 in cycle 2. Latency is 2 cycles with the FIFO empty and the FSM in IDLE.
- Throughput: one byte per cycle with `byte_ready` held high, i.e. 6 cycles per sample.
- `fill_level` updates one cycle after a write or pop, registered.
- The FIFO cannot overflow with `byte_ready` high at 384 kHz output rate. Overflow is only reachable through consumer stall.

## Structure
- Package `rx_iq_pkg`:
  - `BYTES_PER_SAMPLE`=6
  - `SAMPLE_W`=24
  - byte-index type (3 bits)
  - FSM state enum {IDLE, SEND}
- Sub-module `rx_iq_fifo`: synchronous FIFO.
  - 48-bit width, `DEPTH` entries.
  - Ports: write, read, full, empty, level.
  - Read data available in the same cycle as the read (show-ahead).
- The top level holds the FSM, shift register, counters and overflow logic.

## Test plan
- **Single sample:** after reset, one strobe with I=0x123456, Q=0xABCDEF, `byte_ready`=1.
  - `byte_valid` is first seen in cycle 2.
  - Bytes 12,34,56,AB,CD,EF arrive on consecutive cycles, then IDLE.
  - `byte_sob` is high on byte 0x12.
- **Back-to-back samples:** strobes every 6 cycles, 126 samples, `SAMPLES_PER_BLOCK`=63, `byte_ready`=1.
  - Continuous `byte_valid` with no bubble.
  - `byte_sob` at bytes 0 and 378.
  - `byte_eob` at bytes 377 and 755.
- **Backpressure:** `byte_ready` toggled at random.
  - Byte stream identical to the ready-high reference.
  - Outputs held stable during every stall.
- **Overflow:** `DEPTH`=16, `byte_ready`=0, 20 strobes.
  - `fill_level`=16 when the shift register holds sample 0 (FIFO holds samples 1..16).
  - `overflow`=1 and `overflow_count`=3.
  - On release, 17 samples are emitted in order.
- **Full plus simultaneous pop:** FIFO full, strobe in the same cycle as the byte-5 handshake.
  - Sample accepted; `overflow_count` unchanged.
- **Flush:** `enable`=0 for 1 cycle mid-sample (byte index 3) with 5 samples queued.
  - `byte_valid`=0 on the next cycle; `fill_level`=0.
  - The next strobe produces `byte_sob`=1 on its first byte.
  - `overflow_count` preserved.
